// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue sequencer: 2-entry skid FIFO toward the alu, branch redirect hold toward fetch,
// and wrong-path shadow flush. Optional performance counters are enabled by defining ALU_ISSUE_PERF_EN.
module alu_issue_ctrl #(
    parameter int FLUSH_DEPTH = 2,
    parameter int CW          = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dec_valid,
    output logic        dec_retry,
    input  logic [31:0] dec_insn,
    input  logic [63:0] dec_pc,
    input  logic [63:0] dec_sign_ext,
    input  logic [63:0] dec_src1,
    input  logic [63:0] dec_src2,
    output logic        alu_insn_valid,
    input  logic        alu_insn_retry,
    output logic [31:0] alu_insn,
    output logic [63:0] alu_pc,
    output logic [63:0] alu_sign_ext,
    output logic [63:0] alu_src1,
    output logic [63:0] alu_src2,
    input  logic        alu_br_valid,
    input  logic [63:0] alu_br_target,
    output logic        branch_target_valid,
    output logic [63:0] branch_target,
    input  logic        branch_target_retry
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_dropped
`endif
);

    localparam int EW = 32 + 4 * 64;
    localparam logic [CW-1:0] FD_C    = CW'(FLUSH_DEPTH);
    localparam logic [CW-1:0] FD_M1_C = (FLUSH_DEPTH > 0) ? CW'(FLUSH_DEPTH - 1) : {CW{1'b0}};

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_HOLD = 2'd1,
        FLUSH   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      count_q, count_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic [EW-1:0]   mem0_q, mem0_d;
    logic [EW-1:0]   mem1_q, mem1_d;
    logic [63:0]     hold_q, hold_d;
    logic [CW-1:0]   flush_cnt_q, flush_cnt_d;

    logic            dec_xfer_s, issue_s, redirect_acc_s;
    logic            push_s, pop_s, clear_s;
    logic [CW-1:0]   cnt_load_s, cnt_dec_s;
    logic [EW-1:0]   dec_bundle_s, head_s;

    assign dec_bundle_s = {dec_insn, dec_pc, dec_sign_ext, dec_src1, dec_src2};
    assign head_s       = rd_ptr_q ? mem1_q : mem0_q;
    assign {alu_insn, alu_pc, alu_sign_ext, alu_src1, alu_src2} = head_s;

    // All handshake outputs decode registered state only.
    assign dec_retry           = (count_q == 2'd2);
    assign alu_insn_valid      = (count_q != 2'd0) && (state_q != BR_HOLD);
    assign branch_target_valid = (state_q == BR_HOLD);
    assign branch_target       = hold_q;

    assign dec_xfer_s     = dec_valid && !dec_retry;
    assign issue_s        = alu_insn_valid && !alu_insn_retry;
    assign redirect_acc_s = branch_target_valid && !branch_target_retry;
    // A decode transfer coinciding with the redirect accept already consumes one shadow slot.
    assign cnt_load_s     = dec_xfer_s ? FD_M1_C : FD_C;
    assign cnt_dec_s      = (flush_cnt_q != {CW{1'b0}}) ? (flush_cnt_q - CW'(1)) : {CW{1'b0}};

    // Next-state, FIFO bookkeeping, redirect hold and shadow counter.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        mem0_d      = mem0_q;
        mem1_d      = mem1_q;
        hold_d      = hold_q;
        flush_cnt_d = flush_cnt_q;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        clear_s     = 1'b0;

        case (state_q)
            RUN: begin
                push_s = dec_xfer_s;
                pop_s  = issue_s;
                if (issue_s && alu_br_valid) begin
                    hold_d  = alu_br_target;
                    state_d = BR_HOLD;
                end else begin
                    state_d = RUN;
                end
            end
            BR_HOLD: begin
                if (redirect_acc_s) begin
                    clear_s     = 1'b1;
                    hold_d      = 64'd0;
                    flush_cnt_d = cnt_load_s;
                    state_d     = (cnt_load_s != {CW{1'b0}}) ? FLUSH : RUN;
                end else begin
                    push_s = dec_xfer_s;
                end
            end
            FLUSH: begin
                if (dec_xfer_s) begin
                    flush_cnt_d = cnt_dec_s;
                    state_d     = (cnt_dec_s == {CW{1'b0}}) ? RUN : FLUSH;
                end else begin
                    state_d     = (flush_cnt_q == {CW{1'b0}}) ? RUN : FLUSH;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (clear_s) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (push_s) begin
                if (wr_ptr_q) begin
                    mem1_d = dec_bundle_s;
                end else begin
                    mem0_d = dec_bundle_s;
                end
                wr_ptr_d = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            count_q     <= 2'd0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            mem0_q      <= {EW{1'b0}};
            mem1_q      <= {EW{1'b0}};
            hold_q      <= 64'd0;
            flush_cnt_q <= {CW{1'b0}};
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            mem0_q      <= mem0_d;
            mem1_q      <= mem1_d;
            hold_q      <= hold_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_dropped_q, perf_dropped_d;
    logic        drop_dec_s;

    assign drop_dec_s = dec_xfer_s &&
                        (((state_q == BR_HOLD) && redirect_acc_s) || (state_q == FLUSH));

    // Counter increments; all wrap naturally at 32 bits.
    always_comb begin
        perf_issued_d  = perf_issued_q + {31'd0, issue_s};
        perf_stall_d   = perf_stall_q + {31'd0, (count_q != 2'd0) && !issue_s};
        perf_dropped_d = perf_dropped_q + {30'd0, (clear_s ? count_q : 2'd0)} + {31'd0, drop_dec_s};
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_issued_q  <= 32'd0;
            perf_stall_q   <= 32'd0;
            perf_dropped_q <= 32'd0;
        end else begin
            perf_issued_q  <= perf_issued_d;
            perf_stall_q   <= perf_stall_d;
            perf_dropped_q <= perf_dropped_d;
        end
    end

    assign perf_issued  = perf_issued_q;
    assign perf_stall   = perf_stall_q;
    assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus a randomized run against a queue-based model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        dec_valid;
    logic [31:0] dec_insn;
    logic [63:0] dec_pc, dec_sign_ext, dec_src1, dec_src2;
    logic        alu_insn_retry, alu_br_valid, branch_target_retry;
    logic [63:0] alu_br_target;

    logic        dec_retry, alu_insn_valid, branch_target_valid;
    logic [31:0] alu_insn;
    logic [63:0] alu_pc, alu_sign_ext, alu_src1, alu_src2, branch_target;

    logic        d1_dec_retry, d1_alu_insn_valid, d1_branch_target_valid;
    logic [31:0] d1_alu_insn;
    logic [63:0] d1_alu_pc, d1_alu_sign_ext, d1_alu_src1, d1_alu_src2, d1_branch_target;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [63:0] got[$];

    always #5 clk = ~clk;

    alu_issue_ctrl #(.FLUSH_DEPTH(2), .CW(4)) u_dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_retry(dec_retry), .dec_insn(dec_insn), .dec_pc(dec_pc),
        .dec_sign_ext(dec_sign_ext), .dec_src1(dec_src1), .dec_src2(dec_src2),
        .alu_insn_valid(alu_insn_valid), .alu_insn_retry(alu_insn_retry), .alu_insn(alu_insn),
        .alu_pc(alu_pc), .alu_sign_ext(alu_sign_ext), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_br_valid(alu_br_valid), .alu_br_target(alu_br_target),
        .branch_target_valid(branch_target_valid), .branch_target(branch_target),
        .branch_target_retry(branch_target_retry)
    );

    alu_issue_ctrl #(.FLUSH_DEPTH(1), .CW(4)) u_dut1 (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_retry(d1_dec_retry), .dec_insn(dec_insn), .dec_pc(dec_pc),
        .dec_sign_ext(dec_sign_ext), .dec_src1(dec_src1), .dec_src2(dec_src2),
        .alu_insn_valid(d1_alu_insn_valid), .alu_insn_retry(alu_insn_retry), .alu_insn(d1_alu_insn),
        .alu_pc(d1_alu_pc), .alu_sign_ext(d1_alu_sign_ext), .alu_src1(d1_alu_src1), .alu_src2(d1_alu_src2),
        .alu_br_valid(alu_br_valid), .alu_br_target(alu_br_target),
        .branch_target_valid(d1_branch_target_valid), .branch_target(d1_branch_target),
        .branch_target_retry(branch_target_retry)
    );

    task automatic idle_inputs();
        dec_valid = 1'b0; dec_insn = 32'd0; dec_pc = 64'd0; dec_sign_ext = 64'd0;
        dec_src1 = 64'd0; dec_src2 = 64'd0; alu_insn_retry = 1'b0; alu_br_valid = 1'b0;
        alu_br_target = 64'd0; branch_target_retry = 1'b0;
    endtask

    task automatic set_bundle(input logic [63:0] pc);
        dec_valid    = 1'b1;
        dec_pc       = pc;
        dec_insn     = pc[31:0] ^ 32'h5A5A_0000;
        dec_sign_ext = ~pc;
        dec_src1     = pc + 64'd1;
        dec_src2     = pc + 64'd2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        n_cmp++; if (dec_retry !== 1'b0) begin n_fail++; $display("FAIL reset_dec_retry: got %b exp 0", dec_retry); end
        n_cmp++; if (alu_insn_valid !== 1'b0) begin n_fail++; $display("FAIL reset_alu_valid: got %b exp 0", alu_insn_valid); end
        n_cmp++; if ({alu_insn, alu_pc, alu_sign_ext, alu_src1, alu_src2} !== 288'd0) begin n_fail++; $display("FAIL reset_payload: pc %h exp 0", alu_pc); end
        n_cmp++; if ({branch_target_valid, branch_target} !== 65'd0) begin n_fail++; $display("FAIL reset_branch: got %b/%h exp 0/0", branch_target_valid, branch_target); end
        reset = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        set_bundle(64'h100);
        dec_src1 = 64'd5;
        n_cmp++; if (alu_insn_valid !== 1'b0) begin n_fail++; $display("FAIL single_pre_valid: got %b exp 0", alu_insn_valid); end
        @(negedge clk);
        dec_valid = 1'b0;
        n_cmp++; if (alu_insn_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b exp 1", alu_insn_valid); end
        n_cmp++; if (alu_pc !== 64'h100) begin n_fail++; $display("FAIL single_pc: got %h exp 100", alu_pc); end
        n_cmp++; if (alu_src1 !== 64'd5) begin n_fail++; $display("FAIL single_src1: got %h exp 5", alu_src1); end
        @(negedge clk);
        n_cmp++; if (alu_insn_valid !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle: got %b exp 0", alu_insn_valid); end
    endtask

    task automatic test_backpressure();
        logic drop_next;
        do_reset();
        alu_insn_retry = 1'b1;
        set_bundle(64'h200);
        @(negedge clk);
        set_bundle(64'h210);
        n_cmp++; if (dec_retry !== 1'b0) begin n_fail++; $display("FAIL bp_retry_1: got %b exp 0", dec_retry); end
        @(negedge clk);
        set_bundle(64'h220);
        n_cmp++; if (dec_retry !== 1'b1) begin n_fail++; $display("FAIL bp_retry_full: got %b exp 1", dec_retry); end
        n_cmp++; if (alu_pc !== 64'h200) begin n_fail++; $display("FAIL bp_head: got %h exp 200", alu_pc); end
        @(negedge clk);
        n_cmp++; if (alu_pc !== 64'h200 || alu_insn_valid !== 1'b1) begin n_fail++; $display("FAIL bp_head_stable: got %h/%b exp 200/1", alu_pc, alu_insn_valid); end
        alu_insn_retry = 1'b0;
        got.delete();
        drop_next = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            if (drop_next) dec_valid = 1'b0;
            if (alu_insn_valid) got.push_back(alu_pc);
            drop_next = dec_valid && !dec_retry;
        end
        n_cmp++; if (got.size() != 3) begin n_fail++; $display("FAIL bp_issue_count: got %0d exp 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== 64'h200 + 64'h10 * i) begin n_fail++; $display("FAIL bp_order[%0d]: got %h exp %h", i, got[i], 64'h200 + 64'h10 * i); end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        branch_target_retry = 1'b1;
        set_bundle(64'h300);
        @(negedge clk);
        n_cmp++; if (alu_insn_valid !== 1'b1) begin n_fail++; $display("FAIL redir_issue_valid: got %b exp 1", alu_insn_valid); end
        set_bundle(64'h310);
        alu_br_valid  = 1'b1;
        alu_br_target = 64'h2000;
        @(negedge clk);
        alu_br_valid = 1'b0;
        set_bundle(64'h320);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 1) dec_valid = 1'b0;
            n_cmp++; if (branch_target_valid !== 1'b1 || branch_target !== 64'h2000) begin
                n_fail++; $display("FAIL redir_hold[%0d]: got %b/%h exp 1/2000", i, branch_target_valid, branch_target); end
            n_cmp++; if (alu_insn_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stall[%0d]: got %b exp 0", i, alu_insn_valid); end
            if (i == 2) begin
                n_cmp++; if (dec_retry !== 1'b1) begin n_fail++; $display("FAIL redir_fifo_full: got %b exp 1", dec_retry); end
            end
            if (i == 3) branch_target_retry = 1'b0;
        end
        @(negedge clk);
        n_cmp++; if (branch_target_valid !== 1'b0) begin n_fail++; $display("FAIL redir_accepted: got %b exp 0", branch_target_valid); end
        n_cmp++; if (alu_insn_valid !== 1'b0 || dec_retry !== 1'b0) begin n_fail++; $display("FAIL redir_fifo_cleared: valid %b retry %b exp 0/0", alu_insn_valid, dec_retry); end
    endtask

    task automatic test_flush_shadow();
        do_reset();
        set_bundle(64'h400);
        @(negedge clk);
        dec_valid     = 1'b0;
        alu_br_valid  = 1'b1;
        alu_br_target = 64'h3000;
        @(negedge clk);
        alu_br_valid = 1'b0;
        n_cmp++; if (branch_target !== 64'h3000) begin n_fail++; $display("FAIL flush_target: got %h exp 3000", branch_target); end
        @(negedge clk);
        got.delete();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            if (alu_insn_valid) got.push_back(alu_pc);
            if (i < 3) set_bundle(64'h410 + 64'h10 * i);
            else dec_valid = 1'b0;
        end
        n_cmp++; if (got.size() != 1) begin n_fail++; $display("FAIL flush_issue_count: got %0d exp 1", got.size()); end
        if (got.size() > 0) begin
            n_cmp++; if (got[0] !== 64'h430) begin n_fail++; $display("FAIL flush_survivor: got %h exp 430", got[0]); end
        end
    endtask

    task automatic test_same_cycle_drop();
        do_reset();
        set_bundle(64'h500);
        @(negedge clk);
        dec_valid           = 1'b0;
        alu_br_valid        = 1'b1;
        alu_br_target       = 64'h4000;
        branch_target_retry = 1'b1;
        @(negedge clk);
        alu_br_valid = 1'b0;
        n_cmp++; if (d1_branch_target_valid !== 1'b1) begin n_fail++; $display("FAIL same_hold: got %b exp 1", d1_branch_target_valid); end
        branch_target_retry = 1'b0;
        set_bundle(64'h510);
        @(negedge clk);
        n_cmp++; if (d1_branch_target_valid !== 1'b0) begin n_fail++; $display("FAIL same_accept: got %b exp 0", d1_branch_target_valid); end
        got.delete();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            if (d1_alu_insn_valid) got.push_back(d1_alu_pc);
            if (i == 0) set_bundle(64'h520);
            else dec_valid = 1'b0;
        end
        n_cmp++; if (got.size() != 1) begin n_fail++; $display("FAIL same_issue_count: got %0d exp 1", got.size()); end
        if (got.size() > 0) begin
            n_cmp++; if (got[0] !== 64'h520) begin n_fail++; $display("FAIL same_survivor: got %h exp 520", got[0]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_bundle(64'h600);
        @(negedge clk);
        set_bundle(64'h610);
        alu_br_valid        = 1'b1;
        alu_br_target       = 64'h5000;
        branch_target_retry = 1'b1;
        @(negedge clk);
        alu_br_valid = 1'b0;
        set_bundle(64'h620);
        @(negedge clk);
        dec_valid = 1'b0;
        n_cmp++; if (dec_retry !== 1'b1 || branch_target_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre_state: retry %b btv %b exp 1/1", dec_retry, branch_target_valid); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if ({dec_retry, alu_insn_valid, branch_target_valid} !== 3'b000) begin
            n_fail++; $display("FAIL mid_async_flags: got %b exp 000", {dec_retry, alu_insn_valid, branch_target_valid}); end
        n_cmp++; if (alu_pc !== 64'd0 || branch_target !== 64'd0) begin
            n_fail++; $display("FAIL mid_async_data: pc %h bt %h exp 0/0", alu_pc, branch_target); end
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        set_bundle(64'h630);
        @(negedge clk);
        dec_valid = 1'b0;
        n_cmp++; if (alu_insn_valid !== 1'b1 || alu_pc !== 64'h630) begin
            n_fail++; $display("FAIL mid_after_reset: got %b/%h exp 1/630", alu_insn_valid, alu_pc); end
    endtask

    task automatic test_random();
        logic [63:0] mq[$];
        int          mode;       // 0 run, 1 holding redirect, 2 dropping shadow
        int          left;
        logic [63:0] mhold;
        logic [63:0] pc_seq;
        logic        e_retry, e_valid, e_btv, dx, iss, acc;
        do_reset();
        mode   = 0;
        left   = 0;
        mhold  = 64'd0;
        pc_seq = 64'h1_0000;
        for (int i = 0; i < 600; i++) begin
            if (i > 0) @(negedge clk);
            e_retry = (mq.size() == 2);
            e_valid = (mq.size() > 0) && (mode != 1);
            e_btv   = (mode == 1);
            n_cmp++; if (dec_retry !== e_retry) begin n_fail++; $display("FAIL rnd_dec_retry@%0d: got %b exp %b", i, dec_retry, e_retry); end
            n_cmp++; if (alu_insn_valid !== e_valid) begin n_fail++; $display("FAIL rnd_alu_valid@%0d: got %b exp %b", i, alu_insn_valid, e_valid); end
            n_cmp++; if (branch_target_valid !== e_btv) begin n_fail++; $display("FAIL rnd_btv@%0d: got %b exp %b", i, branch_target_valid, e_btv); end
            if (e_valid) begin
                n_cmp++; if (alu_pc !== mq[0] || alu_insn !== (mq[0][31:0] ^ 32'h5A5A_0000) || alu_src2 !== mq[0] + 64'd2) begin
                    n_fail++; $display("FAIL rnd_payload@%0d: got pc %h exp %h", i, alu_pc, mq[0]); end
            end
            if (e_btv) begin
                n_cmp++; if (branch_target !== mhold) begin n_fail++; $display("FAIL rnd_target@%0d: got %h exp %h", i, branch_target, mhold); end
            end

            if ($urandom_range(1, 0) == 1) set_bundle(pc_seq);
            else dec_valid = 1'b0;
            pc_seq              = pc_seq + 64'h10;
            alu_insn_retry      = ($urandom_range(3, 0) == 0);
            alu_br_valid        = ($urandom_range(4, 0) == 0);
            alu_br_target       = {$urandom, $urandom};
            branch_target_retry = ($urandom_range(1, 0) == 1);

            dx  = dec_valid && !e_retry;
            iss = e_valid && !alu_insn_retry;
            acc = e_btv && !branch_target_retry;
            if (mode == 0) begin
                if (iss) void'(mq.pop_front());
                if (dx) mq.push_back(dec_pc);
                if (iss && alu_br_valid) begin mode = 1; mhold = alu_br_target; end
            end else if (mode == 1) begin
                if (acc) begin
                    mq.delete();
                    left = 2 - (dx ? 1 : 0);
                    mode = (left > 0) ? 2 : 0;
                end else if (dx) begin
                    mq.push_back(dec_pc);
                end
            end else begin
                if (dx) begin
                    left = (left > 0) ? left - 1 : 0;
                    if (left == 0) mode = 0;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_redirect();
        test_flush_shadow();
        test_same_cycle_drop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
